// File: rtl/soc_system_led_pwm_fader.sv
// LED PWM fader: each channel ramps its brightness linearly toward the led_in target, one step per STEP_DIV clocks.
// Define LED_FADE_GAMMA_EN to map level to duty through a square-law curve instead of linearly.
module soc_system_led_pwm_fader #(
   parameter int NUM_LEDS = 8,
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 1000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_LEDS-1:0] led_in,
   input  logic                enable,
   output logic [NUM_LEDS-1:0] led_out,
   output logic                busy
);

   localparam logic [PWM_BITS-1:0] MAX_LEVEL = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] PWM_LAST  = MAX_LEVEL - PWM_BITS'(1);
   localparam int                  STEP_W    = $clog2(STEP_DIV);
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {ST_OFF, ST_RISE, ST_ON, ST_FALL} state_t;

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
   logic                step_tick;
   logic [NUM_LEDS-1:0] led_out_d;
   logic [NUM_LEDS-1:0] moving_d;
   logic                busy_d;

   always_comb begin
      pwm_cnt_d  = '0;
      step_cnt_d = '0;
      if (enable) begin
         pwm_cnt_d  = (pwm_cnt_q == PWM_LAST)   ? '0 : pwm_cnt_q + PWM_BITS'(1);
         step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + STEP_W'(1);
      end
   end

   assign step_tick = enable && (step_cnt_q == STEP_LAST);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
         logic [PWM_BITS-1:0] level_q, level_d;
         logic [PWM_BITS-1:0] duty;
         state_t              state_q, state_d;

         // Direction is taken from led_in on the tick itself, so a reversal continues from the current level.
         always_comb begin
            level_d = level_q;
            state_d = state_q;
            if (step_tick) begin
               if (led_in[gi] && (level_q != MAX_LEVEL))
                  level_d = level_q + PWM_BITS'(1);
               else if (!led_in[gi] && (level_q != '0))
                  level_d = level_q - PWM_BITS'(1);
            end
            if (enable) begin
               if (led_in[gi])
                  state_d = (level_d == MAX_LEVEL) ? ST_ON : ST_RISE;
               else
                  state_d = (level_d != '0) ? ST_FALL : ST_OFF;
            end
         end

`ifdef LED_FADE_GAMMA_EN
         logic [2*PWM_BITS-1:0] level_sq;
         assign level_sq = ({{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q})
                         + {{PWM_BITS{1'b0}}, MAX_LEVEL};
         assign duty = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
         assign duty = level_q;
`endif

         assign led_out_d[gi] = enable && (pwm_cnt_q < duty);
         assign moving_d[gi]  = (state_d == ST_RISE) || (state_d == ST_FALL);

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               level_q <= '0;
               state_q <= ST_OFF;
            end else begin
               level_q <= level_d;
               state_q <= state_d;
            end
         end
      end
   endgenerate

   assign busy_d = |moving_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt_q  <= '0;
         step_cnt_q <= '0;
         led_out    <= '0;
         busy       <= 1'b0;
      end else begin
         pwm_cnt_q  <= pwm_cnt_d;
         step_cnt_q <= step_cnt_d;
         led_out    <= led_out_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_soc_system_led_pwm_fader.sv
// Bench for soc_system_led_pwm_fader: directed fades plus random led_in/enable/reset traffic,
// compared every cycle against a level/target reference model; a second instance measures duty.
module tb_soc_system_led_pwm_fader;

   localparam int NL = 8;
   localparam int PB = 4;
   localparam int ML = 15;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          reset_n, enable;
   logic [NL-1:0] led_in;
   logic [NL-1:0] led_out;
   logic          busy;

   logic          rst2_n, en2;
   logic [NL-1:0] led_in2;
   logic [NL-1:0] led_out2;
   logic          busy2;

   always #5 clk = ~clk;

   soc_system_led_pwm_fader #(.NUM_LEDS(NL), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
      .clk(clk), .reset_n(reset_n), .led_in(led_in), .enable(enable),
      .led_out(led_out), .busy(busy)
   );

   soc_system_led_pwm_fader #(.NUM_LEDS(NL), .PWM_BITS(PB), .STEP_DIV(64)) dut_duty (
      .clk(clk), .reset_n(rst2_n), .led_in(led_in2), .enable(en2),
      .led_out(led_out2), .busy(busy2)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_total++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: t = enabled cycles since counters last restarted; level moves toward target.
   int            m_t;
   int            m_level [NL];
   bit            m_moving[NL];
   logic [NL-1:0] m_out;
   bit            m_busy;

   function automatic int duty_of(input int lvl);
`ifdef LED_FADE_GAMMA_EN
      return (lvl * lvl + ML) / (ML + 1);
`else
      return lvl;
`endif
   endfunction

   task automatic model_reset();
      m_t    = 0;
      m_out  = '0;
      m_busy = 1'b0;
      for (int i = 0; i < NL; i++) begin
         m_level[i]  = 0;
         m_moving[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit tick;
      int phase;
      int target;
      if (!reset_n) begin
         model_reset();
         return;
      end
      if (!enable) begin
         m_t   = 0;
         m_out = '0;
      end else begin
         tick  = ((m_t % SD) == SD - 1);
         phase = m_t % ML;
         for (int i = 0; i < NL; i++) begin
            m_out[i] = (phase < duty_of(m_level[i]));
            if (tick) begin
               if (led_in[i] && m_level[i] < ML) m_level[i]++;
               else if (!led_in[i] && m_level[i] > 0) m_level[i]--;
            end
            target      = led_in[i] ? ML : 0;
            m_moving[i] = (m_level[i] != target);
         end
         m_t++;
      end
      m_busy = 1'b0;
      for (int i = 0; i < NL; i++) if (m_moving[i]) m_busy = 1'b1;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("led_out", led_out, m_out);
      check("busy", busy, m_busy);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_led_out", led_out, 0);
      check("async_rst_busy", busy, 0);
      cyc();
      reset_n = 1'b1;
   endtask

   task automatic count_highs2(input int n, output int hi);
      hi = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         hi += led_out2[0];
      end
   endtask

   initial begin
      int hi;
      reset_n = 1'b0; enable = 1'b1; led_in = 8'hFF;
      rst2_n  = 1'b0; en2    = 1'b1; led_in2 = 8'h01;
      model_reset();

      // Duty measurement on the STEP_DIV=64 instance: edge t uses the level reached before t.
      repeat (2) @(posedge clk);
      #1;
      rst2_n = 1'b1;
      count_highs2(15, hi);                 // edges 0..14, level 0
      check("duty_level0", hi, duty_of(0));
      repeat (185) @(posedge clk);          // edges 15..199
      count_highs2(15, hi);                 // edges 200..214, level 3
      check("duty_level3", hi, duty_of(3));
      repeat (305) @(posedge clk);          // edges 215..519
      count_highs2(15, hi);                 // edges 520..534, level 8
      check("duty_level8", hi, duty_of(8));

      // Reset state with all targets on, then busy rises one cycle after release.
      repeat (2) cyc();
      check("rst_led_out", led_out, 0);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      cyc();
      check("busy_after_release", busy, 1);

      // Full rise on channel 0.
      led_in = 8'h01;
      do_reset();
      repeat (62) cyc();
      check("rise_busy_idle", busy, 0);
      hi = 0;
      for (int k = 0; k < 15; k++) begin
         cyc();
         hi += led_out[0];
         check("rise_others_off", led_out[7:1], 0);
      end
      check("rise_full_on", hi, 15);

      // Reversal at level 7.
      do_reset();
      repeat (7 * SD) cyc();
      led_in = 8'h00;
      repeat (7 * SD + 4) cyc();
      check("reverse_busy_idle", busy, 0);
      check("reverse_led_off", led_out[0], 0);

      // Enable off mid-fade, resume, then reset mid-fade.
      led_in = 8'hFF;
      do_reset();
      repeat (5 * SD) cyc();
      enable = 1'b0;
      cyc();
      check("disable_blank", led_out, 0);
      check("disable_busy_frozen", busy, 1);
      repeat (9) cyc();
      enable = 1'b1;
      repeat (4 * SD) cyc();
      do_reset();

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 19) == 0) led_in = 8'($urandom);
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         if ($urandom_range(0, 299) == 0) begin
            enable = 1'b1;
            do_reset();
         end else begin
            cyc();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
